// File: rtl/mul_accumulator.sv
// Saturating multiply-accumulate stage: sums DEPTH multiplier products into an
// N-bit result with sticky overflow, then offers it downstream via valid/ready.
module mul_accumulator #(
  parameter int N     = 7,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_prod,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     acc_out,
  output logic             acc_ovf,
  output logic [CNT_W-1:0] count
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     acc, acc_nxt;
  logic             ovf, ovf_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N:0]       sum;
  logic             accept, take;

  always_comb begin
    // Handshake outputs decode only state and clr, never in_valid/out_ready.
    in_ready  = (state == ACCUM) && !clr;
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
    take      = out_valid && out_ready;
    sum       = {1'b0, acc} + {1'b0, in_prod};
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    if (clr || take) begin
      state_nxt = ACCUM;
      acc_nxt   = '0;
      ovf_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else if (accept) begin
      if (sum[N] || in_cout || ovf) begin
        acc_nxt = '1;
        ovf_nxt = 1'b1;
      end else begin
        acc_nxt = sum[N-1:0];
      end
      cnt_nxt = cnt + 1'b1;
      if (cnt_nxt == CNT_W'(DEPTH)) state_nxt = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign acc_out = acc;
  assign acc_ovf = ovf;
  assign count   = cnt;

endmodule

// File: tb/tb_mul_accumulator.sv
// Bench for mul_accumulator: directed scenarios plus random traffic, all checked
// against an integer-arithmetic burst model.
module tb_mul_accumulator;
  localparam int N = 7, DEPTH = 4, CNT_W = 3;
  localparam int MAXV = (1 << N) - 1;

  logic clk = 1'b0, rst, clr, in_valid, in_ready, in_cout, out_valid, out_ready, acc_ovf;
  logic [N-1:0]     in_prod, acc_out;
  logic [CNT_W-1:0] count;

  int n_cmp = 0, n_err = 0;
  int m_acc, m_ovf, m_cnt;
  bit m_done;

  mul_accumulator #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_cout(in_cout), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .acc_ovf(acc_ovf), .count(count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, clock, advance model.
  task automatic step(input bit v, input int p, input bit c, input bit ordy,
                      input bit cl, input bit rs);
    in_valid = v; in_prod = p[N-1:0]; in_cout = c; out_ready = ordy; clr = cl; rst = rs;
    #1;
    if (!rs) chk("in_ready", in_ready, !m_done && !cl);
    chk("out_valid", out_valid, m_done);
    chk("acc_out", acc_out, m_acc);
    chk("acc_ovf", acc_ovf, m_ovf);
    chk("count", count, m_cnt);
    @(posedge clk);
    if (rs || cl || (m_done && ordy)) begin
      m_acc = 0; m_ovf = 0; m_cnt = 0; m_done = 0;
    end else if (!m_done && v) begin
      if (m_ovf != 0 || c || (m_acc + (p & MAXV)) > MAXV) begin
        m_acc = MAXV; m_ovf = 1;
      end else begin
        m_acc = m_acc + (p & MAXV);
      end
      m_cnt++;
      if (m_cnt == DEPTH) m_done = 1;
    end
    #1;
  endtask

  task automatic beat(input int p);
    step(1, p, 0, 1, 0, 0);
  endtask

  task automatic take_result();
    step(0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    int prev;
    rst = 1; clr = 0; in_valid = 0; in_prod = '0; in_cout = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    m_acc = 0; m_ovf = 0; m_cnt = 0; m_done = 0;
    rst = 0;
    #1;
    chk("reset_acc", acc_out, 0);
    chk("reset_ovalid", out_valid, 0);
    chk("reset_iready", in_ready, 1);

    // Basic burst of four 12s
    repeat (4) beat(12);
    chk("basic_ovalid", out_valid, 1);
    chk("basic_sum", acc_out, 48);
    chk("basic_ovf", acc_ovf, 0);
    chk("basic_count", count, 4);
    take_result();
    chk("basic_cleared", acc_out, 0);

    // Sum saturation
    beat(60); beat(60);
    chk("sat_120", acc_out, 120);
    beat(60);
    chk("sat_127", acc_out, 127);
    chk("sat_ovf", acc_ovf, 1);
    beat(1);
    chk("sat_done_ovalid", out_valid, 1);
    chk("sat_done_acc", acc_out, 127);
    take_result();

    // Product overflow on the first beat
    step(1, 97, 1, 1, 0, 0);
    repeat (3) beat(0);
    chk("pov_acc", acc_out, 127);
    chk("pov_ovf", acc_ovf, 1);
    chk("pov_ovalid", out_valid, 1);
    take_result();

    // Back-pressure with toggling in_valid
    beat(3); beat(7); beat(2); beat(9);
    prev = acc_out;
    for (int i = 0; i < 5; i++) begin
      step(i[0], 11, 0, 0, 0, 0);
      chk("bp_iready", in_ready, 0);
      chk("bp_acc", acc_out, prev);
      chk("bp_count", count, 4);
    end
    chk("bp_sum", acc_out, 21);
    take_result();
    chk("bp_released", out_valid, 0);
    chk("bp_resume", in_ready, 1);

    // Clear mid-burst with a competing beat
    beat(5); beat(5);
    step(1, 5, 0, 1, 1, 0);
    chk("clr_acc", acc_out, 0);
    chk("clr_count", count, 0);
    repeat (4) beat(5);
    chk("clr_fresh", acc_out, 20);
    take_result();

    // Reset while a result is pending
    repeat (4) beat(3);
    chk("rst_pre_ovalid", out_valid, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_ovf", acc_ovf, 0);
    chk("rst_count", count, 0);
    rst = 0;
    #1;
    chk("rst_iready", in_ready, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int p;
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 40);
      step($urandom_range(0, 3) != 0, p, $urandom_range(0, 15) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
